// File: rtl/uart_rx_port_pkg.sv
// uart_rx_port_pkg
// Shared definitions for the memory-mapped UART receiver:
//   - register offsets of the DATA and STATUS words
//   - bit positions inside the STATUS word
//   - receiver FSM state encoding
//   - value returned when DATA is read while the FIFO is empty
package uart_rx_port_pkg;

  localparam logic [31:0] UART_RX_DATA   = 32'h0000_0000;
  localparam logic [31:0] UART_RX_STATUS = 32'h0000_0004;

  // The bus carries a single word-select bit, which is bit 2 of the byte offset
  localparam logic ADDR_SEL_DATA   = UART_RX_DATA[2];
  localparam logic ADDR_SEL_STATUS = UART_RX_STATUS[2];

  localparam int ST_NOT_EMPTY = 0;
  localparam int ST_OVERRUN   = 1;
  localparam int ST_FERR      = 2;

  localparam logic [31:0] EMPTY_READ = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_WAIT_HIGH
  } rx_state_e;

endpackage

// File: rtl/uart_rx_port_if.sv
// uart_rx_port_if
// Data-bus connection between the core (master) and the UART receiver (slave).
//   valid  : request, already address-decoded for this peripheral
//   write  : 1 = write, 0 = read
//   wmask  : byte enables for writes
//   wdata  : write data
//   addr   : word select, 0 = DATA, 1 = STATUS
//   rdata  : registered read data, one cycle latency
//   irq    : high while received bytes are waiting
interface uart_rx_port_if;
  logic        valid;
  logic        write;
  logic [3:0]  wmask;
  logic [31:0] wdata;
  logic        addr;
  logic [31:0] rdata;
  logic        irq;

  modport master (
    output valid, write, wmask, wdata, addr,
    input  rdata, irq
  );

  modport slave (
    input  valid, write, wmask, wdata, addr,
    output rdata, irq
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo
// Synchronous byte FIFO of depth 2**FIFO_LOG2 (FIFO_LOG2 >= 1).
//   clk, rstn : clock, asynchronous active-low reset
//   push_i    : write data_i; ignored when full unless pop_i frees a slot
//   pop_i     : drop the head entry; ignored when empty
//   data_i    : byte to store
//   data_o    : current head entry (valid while !empty_o)
//   full_o    : no free slot
//   empty_o   : no entry stored
module uart_rx_fifo #(
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int PW    = FIFO_LOG2 + 1;

  logic [PW-1:0] wrPtr_q, wrPtr_d;
  logic [PW-1:0] rdPtr_q, rdPtr_d;
  logic [7:0]    mem_q [DEPTH];
  logic          doPush;
  logic          doPop;

  // The extra pointer MSB distinguishes a full FIFO from an empty one
  assign empty_o = (wrPtr_q == rdPtr_q);
  assign full_o  = (wrPtr_q[PW-1] != rdPtr_q[PW-1]) &&
                   (wrPtr_q[PW-2:0] == rdPtr_q[PW-2:0]);

  assign doPop  = pop_i & ~empty_o;
  assign doPush = push_i & (~full_o | doPop);

  assign data_o = mem_q[rdPtr_q[PW-2:0]];

  always_comb begin
    wrPtr_d = wrPtr_q;
    rdPtr_d = rdPtr_q;
    if (doPush) wrPtr_d = wrPtr_q + PW'(1);
    if (doPop)  rdPtr_d = rdPtr_q + PW'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
    end
  end

  // Storage needs no reset; the pointers define which entries are meaningful
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q[PW-2:0]] <= data_i;
  end

endmodule

// File: rtl/uart_rx_port.sv
// uart_rx_port
// Memory-mapped 8N1 UART receiver. Frames arriving on rx are deserialised
// into a small FIFO which the core drains through the data bus.
//   clk  : clock, all logic on the rising edge
//   rstn : asynchronous active-low reset
//   rx   : serial input, asynchronous to clk, idle high
//   bus  : slave side of uart_rx_port_if (DATA / STATUS registers, irq)
// STATUS = {29'b0, ferr, overrun, not_empty}; writing 1 to bit 1 / bit 2
// clears overrun / ferr. Reading DATA pops the head byte, or returns all
// ones when nothing has been received.
module uart_rx_port
  import uart_rx_port_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_LOG2    = 2
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic           rx,
  uart_rx_port_if.slave  bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  logic          rxMeta_q, rxSync_q;
  rx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bitCnt_q, bitCnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          overrun_q, overrun_d;
  logic          ferr_q, ferr_d;
  logic [31:0]   rdata_q, rdata_d;

  logic          cntZero;
  logic          stopGood, stopBad;
  logic          isRead, dataRead, popReq, pushReq;
  logic          statusWrite, setOverrun, clrOverrun, clrFerr;
  logic          fifoFull, fifoEmpty;
  logic [7:0]    fifoHead;
  logic [31:0]   statusWord;
  logic          unusedBus;

  // Two-flop synchroniser; resets to the idle line level so that reset
  // release never looks like a start bit
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rxMeta_q <= 1'b1;
      rxSync_q <= 1'b1;
    end else begin
      rxMeta_q <= rx;
      rxSync_q <= rxMeta_q;
    end
  end

  assign cntZero = (cnt_q == '0);

  // Receiver FSM next-state logic. The counter is loaded with half a bit on
  // the start edge so every later sample lands in the middle of a bit.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitCnt_d = bitCnt_q;
    shift_d  = shift_q;
    stopGood = 1'b0;
    stopBad  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!rxSync_q) begin
          state_d = S_START;
          cnt_d   = HALF_LOAD;
        end
      end
      S_START: begin
        if (!cntZero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (!rxSync_q) begin
          state_d  = S_DATA;
          cnt_d    = FULL_LOAD;
          bitCnt_d = 3'd0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (!cntZero) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          shift_d = {rxSync_q, shift_q[7:1]};
          cnt_d   = FULL_LOAD;
          if (bitCnt_q == 3'd7) state_d = S_STOP;
          else bitCnt_d = bitCnt_q + 3'd1;
        end
      end
      S_STOP: begin
        if (!cntZero) begin
          cnt_d = cnt_q - CW'(1);
        end else if (rxSync_q) begin
          stopGood = 1'b1;
          state_d  = S_IDLE;
        end else begin
          stopBad = 1'b1;
          state_d = S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        if (rxSync_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      bitCnt_q <= 3'd0;
      shift_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bitCnt_q <= bitCnt_d;
      shift_q  <= shift_d;
    end
  end

  // Bus decode. A pop in the same cycle as a push into a full FIFO frees
  // the slot, so that byte is accepted rather than counted as an overrun.
  assign isRead      = bus.valid & ~bus.write;
  assign dataRead    = isRead & (bus.addr == ADDR_SEL_DATA);
  assign popReq      = dataRead & ~fifoEmpty;
  assign pushReq     = stopGood & (~fifoFull | popReq);
  assign setOverrun  = stopGood & fifoFull & ~popReq;
  assign statusWrite = bus.valid & bus.write & bus.wmask[0] &
                       (bus.addr == ADDR_SEL_STATUS);
  assign clrOverrun  = statusWrite & bus.wdata[ST_OVERRUN];
  assign clrFerr     = statusWrite & bus.wdata[ST_FERR];
  assign unusedBus   = ^{bus.wmask[3:1], bus.wdata[31:3], bus.wdata[0]};

  uart_rx_fifo #(
    .FIFO_LOG2 (FIFO_LOG2)
  ) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .push_i  (pushReq),
    .pop_i   (popReq),
    .data_i  (shift_q),
    .data_o  (fifoHead),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  always_comb begin
    statusWord               = 32'd0;
    statusWord[ST_NOT_EMPTY] = ~fifoEmpty;
    statusWord[ST_OVERRUN]   = overrun_q;
    statusWord[ST_FERR]      = ferr_q;
  end

  // Sticky flags: a set arriving together with a clear must not be lost,
  // so the set term is ORed in after the clear is applied
  always_comb begin
    overrun_d = setOverrun | (overrun_q & ~clrOverrun);
    ferr_d    = stopBad | (ferr_q & ~clrFerr);
  end

  // Read data is captured on the edge that samples the request and holds
  // otherwise, matching the data memory latency seen by the core
  always_comb begin
    rdata_d = rdata_q;
    if (isRead) begin
      if (bus.addr == ADDR_SEL_STATUS) rdata_d = statusWord;
      else if (fifoEmpty)              rdata_d = EMPTY_READ;
      else                             rdata_d = {24'd0, fifoHead};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      overrun_q <= 1'b0;
      ferr_q    <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      overrun_q <= overrun_d;
      ferr_q    <= ferr_d;
      rdata_q   <= rdata_d;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.irq   = ~fifoEmpty;

endmodule

// File: tb/tb_uart_rx_port.sv
// tb_uart_rx_port
// Scoreboard bench for uart_rx_port with CLKS_PER_BIT = 16 and a 4-entry FIFO.
// Bytes expected in the FIFO are queued when their frame is driven and
// popped when the DUT returns them on a DATA read.
module tb_uart_rx_port;

  localparam int CPB = 16;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic rx   = 1'b1;

  int testsRun    = 0;
  int testsFailed = 0;

  logic [7:0] expQ[$];

  uart_rx_port_if busIf ();

  uart_rx_port #(
    .CLKS_PER_BIT (CPB),
    .FIFO_LOG2    (2)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .rx   (rx),
    .bus  (busIf)
  );

  always #5 clk = ~clk;

  // One-cycle bus read; the result is sampled half a cycle after the edge
  task automatic busRead(input logic a, output logic [31:0] d);
    @(negedge clk);
    busIf.valid = 1'b1;
    busIf.write = 1'b0;
    busIf.addr  = a;
    @(negedge clk);
    busIf.valid = 1'b0;
    d = busIf.rdata;
  endtask

  task automatic busWrite(input logic a, input logic [31:0] w);
    @(negedge clk);
    busIf.valid = 1'b1;
    busIf.write = 1'b1;
    busIf.wmask = 4'hF;
    busIf.addr  = a;
    busIf.wdata = w;
    @(negedge clk);
    busIf.valid = 1'b0;
    busIf.write = 1'b0;
    busIf.wdata = 32'd0;
  endtask

  // Drives one frame plus one idle bit. stopLow extends the low level over
  // the stop bit for that many bit times. readAt >= 0 places a DATA read so
  // that it is sampled on posedge number readAt after the start edge.
  task automatic sendFrame(input logic [7:0] data, input int stopLow,
                           input int readAt, output logic [31:0] readVal,
                           output int irqRise);
    int nBits;
    int b;
    nBits   = 11 + stopLow;
    readVal = 32'hDEAD_BEEF;
    irqRise = -1;
    for (int k = 0; k < nBits * CPB; k++) begin
      @(negedge clk);
      if (irqRise < 0 && busIf.irq === 1'b1) irqRise = k;
      if (k == readAt + 1) begin
        busIf.valid = 1'b0;
        readVal = busIf.rdata;
      end
      if (k % CPB == 0) begin
        b = k / CPB;
        if (b == 0)                 rx = 1'b0;
        else if (b <= 8)            rx = data[b-1];
        else if (b <= 8 + stopLow)  rx = 1'b0;
        else                        rx = 1'b1;
      end
      if (k == readAt) begin
        busIf.valid = 1'b1;
        busIf.write = 1'b0;
        busIf.addr  = 1'b0;
      end
    end
  endtask

  task automatic test_reset;
    logic [31:0] d;
    repeat (3) @(negedge clk);
    testsRun++;
    if (busIf.rdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_rdata: got %h expected %h", busIf.rdata, 32'd0);
    end
    testsRun++;
    if (busIf.irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL reset_irq: got %b expected 0", busIf.irq);
    end
    rstn = 1'b1;
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL reset_status: got %h expected %h", d, 32'd0);
    end
  endtask

  task automatic test_single_byte;
    logic [31:0] d, rv, e;
    int ir;
    sendFrame(8'h41, 0, -1, rv, ir);
    expQ.push_back(8'h41);
    testsRun++;
    if (ir < 154 || ir > 156) begin
      testsFailed++;
      $display("[TB] FAIL irq_latency: got %0d expected 155 +-1", ir);
    end
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL single_status: got %h expected %h", d, 32'h1);
    end
    busRead(1'b0, d);
    e = {24'd0, expQ.pop_front()};
    testsRun++;
    if (d !== e) begin
      testsFailed++;
      $display("[TB] FAIL single_data: got %h expected %h", d, e);
    end
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL single_status_after: got %h expected %h", d, 32'h0);
    end
    testsRun++;
    if (busIf.irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL single_irq_low: got %b expected 0", busIf.irq);
    end
  endtask

  task automatic test_empty_read;
    logic [31:0] d;
    busRead(1'b0, d);
    testsRun++;
    if (d !== 32'hFFFF_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL empty_data: got %h expected %h", d, 32'hFFFF_FFFF);
    end
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL empty_status: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_overrun;
    logic [31:0] d, rv, e;
    int ir;
    logic expOv;
    expOv = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      sendFrame(8'(i), 0, -1, rv, ir);
      if (expQ.size() < 4) expQ.push_back(8'(i));
      else expOv = 1'b1;
    end
    busRead(1'b1, d);
    e = {29'd0, 1'b0, expOv, 1'b1};
    testsRun++;
    if (d !== e) begin
      testsFailed++;
      $display("[TB] FAIL overrun_status_full: got %h expected %h", d, e);
    end
    for (int i = 0; i < 5; i++) begin
      busRead(1'b0, d);
      e = (expQ.size() > 0) ? {24'd0, expQ.pop_front()} : 32'hFFFF_FFFF;
      testsRun++;
      if (d !== e) begin
        testsFailed++;
        $display("[TB] FAIL overrun_read%0d: got %h expected %h", i, d, e);
      end
    end
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h2) begin
      testsFailed++;
      $display("[TB] FAIL overrun_status: got %h expected %h", d, 32'h2);
    end
    busWrite(1'b1, 32'h2);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL overrun_clear: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_framing;
    logic [31:0] d, rv, e;
    int ir;
    sendFrame(8'h55, 3, -1, rv, ir);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h4) begin
      testsFailed++;
      $display("[TB] FAIL ferr_status: got %h expected %h", d, 32'h4);
    end
    testsRun++;
    if (busIf.irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL ferr_irq: got %b expected 0", busIf.irq);
    end
    sendFrame(8'hA5, 0, -1, rv, ir);
    expQ.push_back(8'hA5);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h5) begin
      testsFailed++;
      $display("[TB] FAIL ferr_status_next: got %h expected %h", d, 32'h5);
    end
    busRead(1'b0, d);
    e = {24'd0, expQ.pop_front()};
    testsRun++;
    if (d !== e) begin
      testsFailed++;
      $display("[TB] FAIL ferr_next_data: got %h expected %h", d, e);
    end
    busWrite(1'b1, 32'h4);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL ferr_clear: got %h expected %h", d, 32'h0);
    end
  endtask

  task automatic test_glitch;
    logic [31:0] d, rv, e;
    int ir;
    @(negedge clk);
    rx = 1'b0;
    repeat (4) @(negedge clk);
    rx = 1'b1;
    repeat (3 * CPB) @(negedge clk);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL glitch_status: got %h expected %h", d, 32'h0);
    end
    sendFrame(8'h3C, 0, -1, rv, ir);
    expQ.push_back(8'h3C);
    busRead(1'b0, d);
    e = {24'd0, expQ.pop_front()};
    testsRun++;
    if (d !== e) begin
      testsFailed++;
      $display("[TB] FAIL glitch_next_data: got %h expected %h", d, e);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] d, rv, e;
    int ir;
    for (int i = 0; i < 4; i++) begin
      sendFrame(8'h10 + 8'(i), 0, -1, rv, ir);
      expQ.push_back(8'h10 + 8'(i));
    end
    // Read lands on the STOP sample edge: 2 + CPB/2 + 9*CPB = 154
    sendFrame(8'h14, 0, 154, rv, ir);
    e = {24'd0, expQ.pop_front()};
    expQ.push_back(8'h14);
    testsRun++;
    if (rv !== e) begin
      testsFailed++;
      $display("[TB] FAIL collide_read: got %h expected %h", rv, e);
    end
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h1) begin
      testsFailed++;
      $display("[TB] FAIL collide_status: got %h expected %h", d, 32'h1);
    end
    for (int i = 0; i < 5; i++) begin
      busRead(1'b0, d);
      e = (expQ.size() > 0) ? {24'd0, expQ.pop_front()} : 32'hFFFF_FFFF;
      testsRun++;
      if (d !== e) begin
        testsFailed++;
        $display("[TB] FAIL collide_read%0d: got %h expected %h", i, d, e);
      end
    end
  endtask

  task automatic test_reset_midframe;
    logic [31:0] d, rv;
    int ir;
    sendFrame(8'h77, 0, -1, rv, ir);
    sendFrame(8'h88, 0, -1, rv, ir);
    busRead(1'b1, d);
    @(negedge clk);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    expQ.delete();
    testsRun++;
    if (busIf.rdata !== 32'd0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_rdata: got %h expected %h", busIf.rdata, 32'd0);
    end
    testsRun++;
    if (busIf.irq !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_irq: got %b expected 0", busIf.irq);
    end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    busRead(1'b1, d);
    testsRun++;
    if (d !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL midreset_status: got %h expected %h", d, 32'h0);
    end
    busRead(1'b0, d);
    testsRun++;
    if (d !== 32'hFFFF_FFFF) begin
      testsFailed++;
      $display("[TB] FAIL midreset_data: got %h expected %h", d, 32'hFFFF_FFFF);
    end
  endtask

  initial begin
    busIf.valid = 1'b0;
    busIf.write = 1'b0;
    busIf.wmask = 4'h0;
    busIf.wdata = 32'd0;
    busIf.addr  = 1'b0;
    test_reset();
    test_single_byte();
    test_empty_read();
    test_overrun();
    test_framing();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/uart_rx_port.md
# uart_rx_port

Memory-mapped UART receiver for the RV32 pipeline's data bus. Handles console input, the counterpart of the console-output character port. Deserialises 8N1 frames from the `rx` pin into a small FIFO. The core reads received bytes and status through the same valid/write/wdata/rdata protocol as the data memory, and read data is registered with one-cycle latency.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per serial bit (100 MHz / 115200); must be ≥ 4.
- `FIFO_LOG2`, default 2: log2 of FIFO depth (default 4 entries).
- `clk`  in  1  clock, all logic on rising edge
- `rstn`  in  1  reset, asynchronous, active-low
- `rx`  in  1  serial input, asynchronous to `clk`, idle high
- `valid`  in  1  bus request, already address-decoded for this peripheral
- `write`  in  1  1 = write, 0 = read
- `wmask`  in  4  byte enables for writes
- `wdata`  in  32  write data
- `addr`  in  1  word select: 0 = DATA (offset 0x0), 1 = STATUS (offset 0x4)
- `rdata`  out  32  registered read data
- `irq`  out  1  high while FIFO not empty

## Operation
- **Input synchronisation.** `rx` passes a 2-flop synchroniser; both flops reset to 1.
- **FSM states.** IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE, bit counter 0, cycle counter 0.
- **IDLE.** Synced `rx`==0 → START, cycle counter loads CLKS_PER_BIT/2 − 1.
- **START.** When the counter reaches 0, sample the line. If still 0 → DATA, counter loads CLKS_PER_BIT − 1. If 1 → IDLE (glitch rejected, nothing recorded).
- **DATA.** Sample at each counter expiry and shift in LSB first. After the 8th sample → STOP.
- **STOP.** At counter expiry, sample the line.
  - Sample = 1: push the byte to the FIFO, then → IDLE.
  - Sample = 1 and FIFO full with no same-cycle pop: drop the byte and set sticky `overrun`.
  - Sample = 0: discard the byte, set sticky `ferr`, → WAIT_HIGH.
- **WAIT_HIGH.** Stay until synced `rx`==1, then → IDLE. A break condition therefore yields exactly one `ferr` and no bytes.
- **DATA read** (`valid & !write & addr==0`):
  - FIFO not empty: `rdata` = {24'b0, head byte}, and the head is popped in the request cycle.
  - FIFO empty: `rdata` = 32'hFFFF_FFFF, no state change.
- **STATUS read** (`addr==1`): `rdata` = {29'b0, ferr, overrun, not_empty}. No side effects.
- **STATUS write** (`write & wmask[0] & addr==1`): write-1-to-clear. `wdata[1]` clears `overrun`, `wdata[2]` clears `ferr`.
- **DATA writes** are ignored.
- **Sticky flag collision.** If a set event and a clear of the same flag coincide, set wins.
- **Simultaneous push and pop.** Both take effect and the count is unchanged. When full, the push is accepted because the pop frees a slot; no overrun.
- **FIFO arithmetic.** Read/write pointers are FIFO_LOG2+1 bits wide. Empty when pointers are equal; full when the MSBs differ and the remaining bits are equal. Pointers wrap modulo 2^(FIFO_LOG2+1).
- **Reset values.** `rdata`=0, `irq`=0, FIFO empty, `overrun`=0, `ferr`=0.
- **Reset mid-frame.** Aborts the frame and discards any partial byte. After `rstn` rises, a frame already in progress on the line is resynchronised via IDLE/START; its remainder may produce `ferr`.

## Timing
- `rdata` is updated on the clock edge that samples `valid`. The core sees it in the following cycle, matching memory read latency.
- `rdata` holds its value when there is no read request.
- Pop and the `irq` update take effect on the same edge as the read.
- START→first data sample = CLKS_PER_BIT/2 + CLKS_PER_BIT cycles after the synced falling edge, i.e. mid-bit.
- Byte push occurs on the STOP sample edge. `irq` and `not_empty` are high the cycle after.
- End-to-end: falling edge of the start bit to `irq` = 2 (synchroniser) + CLKS_PER_BIT/2 + 9·CLKS_PER_BIT + 1 cycles, ±1.
- No back-pressure on the bus: every request completes in one cycle.

## Structure
- Shared package/include holds:
  - register offsets `UART_RX_DATA`=0x0 and `UART_RX_STATUS`=0x4
  - status bit positions `ST_NOT_EMPTY`=0, `ST_OVERRUN`=1, `ST_FERR`=2
  - FSM state encodings
  - the empty-read value 32'hFFFF_FFFF
- One sub-module: `uart_rx_fifo`, a synchronous FIFO with push/pop/full/empty and parameter FIFO_LOG2.
- The FSM, synchroniser and bus decode stay in `uart_rx_port`.

## Test plan
All scenarios use CLKS_PER_BIT=16.
- **Single byte.** Send frame 0x41; poll STATUS → 0x1; read DATA → 0x00000041 next cycle; STATUS → 0x0; `irq` low.
- **Empty read.** Read DATA with FIFO empty → 32'hFFFFFFFF; STATUS stays 0x0.
- **Overrun.** Send 5 bytes 0x01..0x05 with no reads:
  - reads return 0x01..0x04, then 32'hFFFFFFFF
  - STATUS → 0x2; write 0x2 to STATUS → 0x0.
- **Framing error.** Send 0x55 with the stop bit held low for 3 bit times, then release. STATUS → 0x4, FIFO empty; the next valid frame 0xA5 is received correctly.
- **Glitch rejection.** A 4-cycle low pulse on `rx` → no byte, no flag, FSM returns to IDLE.
- **Full FIFO with simultaneous read.** With 4 bytes queued, issue a DATA read on the exact cycle of the STOP sample:
  - no overrun; 4 bytes remain
  - ordering is preserved
  - assert `rstn` mid-frame → all outputs 0, FIFO empty.
